// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read-only slave: 16-word register window with ID, read counter
// and address-echo words, programmable wait latency and DECERR outside.
//
// Ports:
//   ACLK     in   1       clock
//   ARESETn  in   1       asynchronous active-low reset
//   araddr   in   ADDR_W  read address
//   arvalid  in   1       address valid
//   arprot   in   3       protection (ignored)
//   arready  out  1       address accepted (registered, high only in IDLE)
//   rdata    out  DATA_W  read data (registered, held until R handshake)
//   rresp    out  2       response: OKAY in window, DECERR outside
//   rvalid   out  1       read data valid
//   rready   in   1       master ready for data
module axi4_lite_read_slave #(
   parameter int                ADDR_W     = 24,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'hAB0B0,
   parameter int                RD_LATENCY = 2
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   input  logic [2:0]        arprot,
   output logic              arready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_DECERR = 2'b11;
   localparam logic [31:0] ID_WORD     = 32'hA0B0_5EED;
   localparam logic [7:0]  ECHO_TAG    = 8'hD0;

   localparam bit         HAS_WAIT = (RD_LATENCY > 0);
   localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY);

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        lat_cnt;
   logic [31:0]       rd_cnt;

   logic              hit;
   logic [3:0]        idx;
   logic [DATA_W-1:0] rd_word;
   logic [1:0]        rd_resp;

   // protection bits carry no meaning for this window
   logic unused_prot;
   assign unused_prot = ^arprot;

   // Decode works on the captured address. rd_cnt cannot move while a
   // transaction is outstanding, so reading it here equals the value seen
   // at AR capture and never includes this read's own increment.
   always_comb begin
      hit     = (addr_q[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
      idx     = addr_q[3:0];
      rd_word = '0;
      rd_resp = RESP_DECERR;
      if (hit) begin
         rd_resp = RESP_OKAY;
         unique case (1'b1)
            (idx == 4'd0): rd_word = DATA_W'(ID_WORD);
            (idx == 4'd1): rd_word = DATA_W'(rd_cnt);
            default:       rd_word = DATA_W'({ECHO_TAG, addr_q});
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state   <= IDLE;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
         rd_cnt  <= '0;
         lat_cnt <= '0;
         addr_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (arvalid && arready) begin
                  addr_q  <= araddr;
                  arready <= 1'b0;
                  if (HAS_WAIT) begin
                     state   <= WAIT;
                     lat_cnt <= LAT_INIT;
                  end else begin
                     state <= RESP;
                  end
               end else begin
                  // also raises arready on the first edge out of reset
                  arready <= 1'b1;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (lat_cnt == 3'd1) begin
                  state <= RESP;
               end
            end
            RESP: begin
               // first RESP edge loads the beat; it then holds until taken
               if (!rvalid) begin
                  rvalid <= 1'b1;
                  rdata  <= rd_word;
                  rresp  <= rd_resp;
               end else if (rready) begin
                  rvalid  <= 1'b0;
                  arready <= 1'b1;
                  state   <= IDLE;
                  if (rresp == RESP_OKAY) begin
                     rd_cnt <= rd_cnt + 32'd1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               arready <= 1'b0;
               rvalid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/axi4_lite_read_slave.md
AXI4_LITE_READ_SLAVE -- requirements
Module: axi4_lite_read_slave

Interface
- REQ-001 SHALL use one clock and an asynchronous, active-low reset: clock ACLK, reset ARESETn (asynchronous assert, active low).
- REQ-002 SHALL take parameter ADDR_W, default 24, address width.
- REQ-003 SHALL take parameter DATA_W, default 32, data width.
- REQ-004 SHALL take parameter BASE_ADDR, default 24'hAB0B0, 16-word window base (low 4 bits ignored).
- REQ-005 SHALL take parameter RD_LATENCY, default 2, wait cycles, legal range 0..7.
- REQ-006 SHALL provide ports as follows:
  - ACLK  in  1  clock
  - ARESETn  in  1  async active-low reset
  - araddr  in  ADDR_W  read address
  - arvalid  in  1  address valid
  - arprot  in  3  protection; ignored
  - arready  out  1  address accepted
  - rdata  out  DATA_W  read data
  - rresp  out  2  response
  - rvalid  out  1  data valid
  - rready  in  1  master ready for data

Function
- REQ-007 SHALL implement FSM states IDLE, WAIT, RESP.
- REQ-008 In IDLE, arready SHALL be 1; all other states SHALL drive arready 0 (registered).
- REQ-009 AR handshake (arvalid&&arready at edge k) SHALL capture araddr into an internal register and clear arready at edge k.
- REQ-010 After the AR handshake, the FSM SHALL enter WAIT if RD_LATENCY>0 (counter loaded with RD_LATENCY), else enter RESP directly.
- REQ-011 WAIT SHALL decrement the counter each cycle and enter RESP when it reaches 1, so rvalid rises at edge k+1+RD_LATENCY.
- REQ-012 In RESP, rvalid, rdata and rresp SHALL be registered and held stable until the R handshake.
- REQ-013 On an R handshake (rvalid&&rready at an edge), rvalid SHALL clear at that edge and the FSM SHALL return to IDLE with arready 1 on that same edge.
- REQ-014 Address decode: in-window SHALL mean araddr[ADDR_W-1:4]==BASE_ADDR[ADDR_W-1:4], with idx=araddr[3:0].
- REQ-015 idx 0 SHALL return the ID constant 32'hA0B0_5EED.
- REQ-016 idx 1 SHALL return read counter rd_cnt.
- REQ-017 idx 2..15 SHALL return {8'hD0, captured araddr}.
- REQ-018 In-window reads SHALL return rresp 2'b00 (OKAY).
- REQ-019 Out-of-window reads SHALL return rresp 2'b11 (DECERR) with rdata 0.
- REQ-020 rd_cnt SHALL be 32 bits, SHALL increment by 1 on each completed R handshake with OKAY, and SHALL wrap FFFF_FFFF->0.
- REQ-021 A read of idx 1 SHALL return rd_cnt as sampled at AR capture, excluding its own increment.
- REQ-022 arvalid held high after acceptance SHALL NOT start a second transaction before return to IDLE.
- REQ-023 The slave SHALL hold exactly one outstanding transaction.
- REQ-024 rready high before rvalid SHALL be legal and SHALL complete the R handshake on the first rvalid cycle.
- REQ-025 arprot and unaligned low bits SHALL have no effect.

Reset
- REQ-026 On ARESETn low, asynchronously: state IDLE, arready 0, rvalid 0, rdata 0, rresp 00, rd_cnt 0, latency counter 0.
- REQ-027 arready SHALL rise on the first ACLK edge with ARESETn high.
- REQ-028 Reset asserted mid-WAIT or mid-RESP SHALL abort the transaction with no response and no rd_cnt change.

Verification
- REQ-029 Read 24'hAB0B9, RD_LATENCY 2, rready 1 -> rvalid at handshake edge +3, rdata 32'hD00AB0B9, rresp 00, then arready 1.
- REQ-030 Read 24'hAB0B0 -> rdata 32'hA0B05EED, OKAY; then read 24'hAB0B1 -> rdata 1.
- REQ-031 Read 24'h000000 -> rdata 0, rresp 11; a following read of idx 1 returns an unchanged rd_cnt.
- REQ-032 Hold rready 0 for 5 cycles in RESP -> rvalid, rdata and rresp stable; single completion when rready rises.
- REQ-033 arvalid held high continuously over 3 reads -> exactly 3 AR handshakes, each separated by full responses.
- REQ-034 Assert ARESETn low during WAIT -> rvalid 0 immediately, rd_cnt 0, arready 1 one edge after release.
